// File: rtl/mem_responder.sv
// Byte-wide RAM/ROM responder for the 6502 bus: decodes RAM/ROM/unmapped, returns data with a one-cycle ready.
// Optional feature macro: ROM_WP_EN (ROM write-protect; undefined = ROM acts as shadow RAM).
`timescale 1ns/1ps
module mem_responder #(
    parameter int          RAM_DEPTH        = 2048,
    parameter logic [15:0] ROM_BASE         = 16'hF000,
    parameter int          ROM_WAIT         = 1,
    parameter logic [15:0] RESET_VECTOR_VAL = 16'hF000,
    parameter string       ROM_FILE         = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [15:0] address,
    input  logic        rw,
    input  logic [7:0]  write_data,
    output logic [7:0]  read_data,
    output logic        ready,
    output logic        bus_err,
    output logic [15:0] debug_access_count
);
    localparam int ROM_SIZE = 65536 - int'(ROM_BASE);
    localparam int RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int ROM_AW   = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;

    typedef enum logic [2:0] {S_IDLE = 3'b001, S_WAIT = 3'b010, S_RESP = 3'b100} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_UNM} region_t;
    typedef logic [7:0] rom_img_t [ROM_SIZE];

    // Unwritten ROM reads as NOP.
    function automatic rom_img_t load_rom();
        rom_img_t img;
        for (int i = 0; i < ROM_SIZE; i++) img[i] = 8'hEA;
        return img;
    endfunction

    logic [7:0] ram_mem [RAM_DEPTH];
    logic [7:0] rom_mem [ROM_SIZE] = load_rom();

    state_t      state_q, state_d;
    region_t     region_q, region_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  read_data_q, read_data_d;
    logic        ready_q, ready_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] count_q, count_d;

    logic [RAM_AW-1:0] ram_idx;
    logic [ROM_AW-1:0] rom_idx;
    logic [7:0]        rd_byte;
    region_t           region_in;
    logic              ram_we;

    assign ram_idx = addr_q[RAM_AW-1:0];
    assign rom_idx = ROM_AW'(addr_q - ROM_BASE);

    // RAM wins when the two windows overlap.
    always_comb begin
        region_in = REG_UNM;
        if (int'(address) < RAM_DEPTH)  region_in = REG_RAM;
        else if (address >= ROM_BASE)   region_in = REG_ROM;
    end

    always_comb begin
        rd_byte = 8'hFF;
        case (region_q)
            REG_RAM: rd_byte = ram_mem[ram_idx];
            REG_ROM: begin
                if (addr_q == 16'hFFFC)      rd_byte = RESET_VECTOR_VAL[7:0];
                else if (addr_q == 16'hFFFD) rd_byte = RESET_VECTOR_VAL[15:8];
                else                         rd_byte = rom_mem[rom_idx];
            end
            default: rd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        ready_d     = 1'b0;
        bus_err_d   = bus_err_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d   = address;
                    rw_d     = rw;
                    wdata_d  = write_data;
                    region_d = region_in;
                    if (region_in == REG_ROM && ROM_WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(ROM_WAIT);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                count_d = count_q + 16'd1;
                if (rw_q) read_data_d = rd_byte;
                if (region_q == REG_UNM) bus_err_d = 1'b1;
`ifdef ROM_WP_EN
                if (region_q == REG_ROM && !rw_q) bus_err_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            region_q    <= REG_UNM;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b1;
            wdata_q     <= 8'h00;
            cnt_q       <= 4'd0;
            read_data_q <= 8'h00;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            count_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            bus_err_q   <= bus_err_d;
            count_q     <= count_d;
        end
    end

    // Arrays commit on the same edge that raises ready; an async reset leaves RESP first.
    assign ram_we = (state_q == S_RESP) && !rw_q && (region_q == REG_RAM);

    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_idx] <= wdata_q;
    end

`ifndef ROM_WP_EN
    logic rom_we;
    assign rom_we = (state_q == S_RESP) && !rw_q && (region_q == REG_ROM);

    always_ff @(posedge clk) begin
        if (rom_we) rom_mem[rom_idx] <= wdata_q;
    end
`endif

    assign read_data          = read_data_q;
    assign ready              = ready_q;
    assign bus_err            = bus_err_q;
    assign debug_access_count = count_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against an address-map reference model.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        rw_i = 1'b1;
  logic [7:0]  write_data = 8'h00;
  logic [7:0]  read_data;
  logic        ready;
  logic        bus_err;
  logic [15:0] debug_access_count;

  mem_responder #(.ROM_WAIT(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .address(address), .rw(rw_i),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .bus_err(bus_err), .debug_access_count(debug_access_count)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  mem_m [int];
  logic [7:0]  rd_m;
  logic        err_m;
  logic [15:0] cnt_m;
  int          ram_list[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [15:0] a);
    if (a < 16'd2048) return 0;
    if (a >= 16'hF000) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int r = region_of(a);
    if (r == 0) return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 8'hXX;
    if (r == 2) return 8'hFF;
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'hF0;
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 8'hEA;
  endfunction

  task automatic model_access(input logic [15:0] a, input logic rw, input logic [7:0] wd);
    int r = region_of(a);
    if (rw) rd_m = model_read(a);
    else if (r == 0) mem_m[int'(a)] = wd;
    else if (r == 1) begin
`ifdef ROM_WP_EN
      err_m = 1'b1;
`else
      mem_m[int'(a)] = wd;
`endif
    end
    if (r == 2) err_m = 1'b1;
    cnt_m = cnt_m + 16'd1;
  endtask

  task automatic model_reset();
    rd_m = 8'h00; err_m = 1'b0; cnt_m = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic do_access(input logic [15:0] a, input logic rw, input logic [7:0] wd, input string tag);
    int lat = 0;
    logic got = 1'b0;
    int exp_lat = (region_of(a) == 1) ? 1 + W : 1;
    @(negedge clk); address = a; rw_i = rw; write_data = wd; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge clk); #1; lat++;
      if (ready) got = 1'b1;
    end
    model_access(a, rw, wd);
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " read_data"}, {8'h00, read_data}, {8'h00, rd_m});
    check({tag, " bus_err"}, {15'h0, bus_err}, {15'h0, err_m});
    check({tag, " count"}, debug_access_count, cnt_m);
    @(posedge clk); #1;
    check({tag, " ready width"}, {15'h0, ready}, 16'h0000);
  endtask

  initial begin
    int pulses, cyc, last;
    model_reset();
    // reset values
    #12;
    check("rst read_data", {8'h00, read_data}, 16'h0000);
    check("rst ready", {15'h0, ready}, 16'h0000);
    check("rst bus_err", {15'h0, bus_err}, 16'h0000);
    check("rst count", debug_access_count, 16'h0000);
    @(negedge clk); reset_n = 1'b1;

    // reset vector fetch
    do_access(16'hFFFC, 1'b1, 8'h00, "vec lo");
    do_access(16'hFFFD, 1'b1, 8'h00, "vec hi");

    // RAM write then read back
    do_access(16'h0010, 1'b0, 8'hA5, "ram wr");
    ram_list.push_back(16'h0010);
    do_access(16'h0010, 1'b1, 8'h00, "ram rd");

    // req held high on a ROM read: one access per 2+W cycles
    @(negedge clk); address = 16'hF005; rw_i = 1'b1; req = 1'b1;
    pulses = 0; cyc = 0; last = 0;
    while (pulses < 3 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (ready) begin
        pulses++;
        if (pulses == 3) req = 1'b0;
        model_access(16'hF005, 1'b1, 8'h00);
        check("held gap", 16'(cyc - last), 16'(2 + W));
        check("held read_data", {8'h00, read_data}, {8'h00, rd_m});
        check("held count", debug_access_count, cnt_m);
        last = cyc;
      end
    end
    req = 1'b0;
    check("held pulses", 16'(pulses), 16'd3);
    @(posedge clk); #1;
    check("held stop", {15'h0, ready}, 16'h0000);

    // ROM write then read
    do_access(16'hF005, 1'b0, 8'h12, "rom wr");
    do_access(16'hF005, 1'b1, 8'h00, "rom rd");
    do_access(16'hFFFC, 1'b0, 8'h77, "vec wr");
    do_access(16'hFFFC, 1'b1, 8'h00, "vec rd");

    // unmapped access, then sticky error
    do_access(16'h4000, 1'b1, 8'h00, "unm rd");
    do_access(16'h0010, 1'b1, 8'h00, "sticky");
    do_access(16'h07FF, 1'b0, 8'h5A, "ram top wr");
    ram_list.push_back(16'h07FF);
    do_access(16'h0800, 1'b0, 8'h66, "unm wr");
    do_access(16'h07FF, 1'b1, 8'h00, "ram top rd");
    do_access(16'hEFFF, 1'b1, 8'h00, "unm top");
    do_access(16'hF000, 1'b1, 8'h00, "rom base");

    // reset during RESP aborts the write
    apply_reset();
    do_access(16'h0020, 1'b0, 8'h00, "pre wr");
    ram_list.push_back(16'h0020);
    @(negedge clk); address = 16'h0020; rw_i = 1'b0; write_data = 8'h3C; req = 1'b1;
    @(posedge clk); #1; req = 1'b0; reset_n = 1'b0;
    check("abort ready", {15'h0, ready}, 16'h0000);
    @(posedge clk); #1;
    check("abort ready2", {15'h0, ready}, 16'h0000);
    model_reset();
    check("abort count", debug_access_count, cnt_m);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort ready3", {15'h0, ready}, 16'h0000);
    do_access(16'h0020, 1'b1, 8'h00, "abort rd");

    // randomized accesses across the map
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 3);
      logic rw_r = 1'($urandom_range(0, 1));
      logic [7:0] wd = 8'($urandom);
      logic [15:0] a;
      case (sel)
        0: begin
          if (rw_r) a = 16'(ram_list[$urandom_range(0, ram_list.size() - 1)]);
          else begin
            a = 16'($urandom_range(0, 2047));
            ram_list.push_back(int'(a));
          end
        end
        1: a = 16'($urandom_range(16'hF000, 16'hFFFF));
        2: a = 16'($urandom_range(16'h0800, 16'hEFFF));
        default: begin a = 16'($urandom_range(16'hFFFC, 16'hFFFD)); rw_r = 1'b1; end
      endcase
      do_access(a, rw_r, wd, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
